// File: rtl/tank_sprite_fetch_if.sv
// Pixel request / aligned sprite-fetch response bundle for tank_sprite_fetch.
// master = pixel source and palette consumer, slave = the fetch pipeline.
interface tank_sprite_fetch_if #(
    parameter int unsigned NUM_TANKS = 4,
    parameter int unsigned X_W       = 10,
    parameter int unsigned Y_W       = 10
);
    localparam int unsigned IdxW = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1;

    logic            pix_valid;
    logic [X_W-1:0]  draw_x;
    logic [Y_W-1:0]  draw_y;
    logic [9:0]      rom_address;
    logic [1:0]      dir_sel;
    logic            enemy;
    logic            hit;
    logic [IdxW-1:0] hit_index;
    logic            out_valid;

    modport master (
        output pix_valid, draw_x, draw_y,
        input  rom_address, dir_sel, enemy, hit, hit_index, out_valid
    );

    modport slave (
        input  pix_valid, draw_x, draw_y,
        output rom_address, dir_sel, enemy, hit, hit_index, out_valid
    );
endinterface

// File: rtl/tank_sprite_fetch.sv
// Per-pixel tank hit test against a frame-latched tank table, issuing sprite ROM addresses and
// sideband delayed to match ROM latency. Optional: SPRITE_OVERLAP_DETECT_EN (overlap flag).
module tank_sprite_fetch #(
    parameter int unsigned NUM_TANKS   = 4,
    parameter int unsigned ROM_LATENCY = 1,
    parameter int unsigned X_W         = 10,
    parameter int unsigned Y_W         = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   frame_start,
    input  logic [NUM_TANKS*X_W-1:0] tank_x,
    input  logic [NUM_TANKS*Y_W-1:0] tank_y,
    input  logic [NUM_TANKS*2-1:0] tank_dir,
    input  logic [NUM_TANKS-1:0]   tank_enemy,
    input  logic [NUM_TANKS-1:0]   tank_alive,
    tank_sprite_fetch_if.slave     pix,
    output logic                   overlap_frame
);
    localparam int unsigned IdxW  = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1;
    localparam int unsigned Depth = ROM_LATENCY + 1;

    // Shadow tank table
    logic [X_W-1:0]       sh_x_q     [NUM_TANKS];
    logic [Y_W-1:0]       sh_y_q     [NUM_TANKS];
    logic [1:0]           sh_dir_q   [NUM_TANKS];
    logic [NUM_TANKS-1:0] sh_enemy_q;
    logic [NUM_TANKS-1:0] sh_alive_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_TANKS; i++) begin
                sh_x_q[i]   <= '0;
                sh_y_q[i]   <= '0;
                sh_dir_q[i] <= '0;
            end
            sh_enemy_q <= '0;
            sh_alive_q <= '0;
        end else if (frame_start) begin
            for (int unsigned i = 0; i < NUM_TANKS; i++) begin
                sh_x_q[i]   <= tank_x[i*X_W +: X_W];
                sh_y_q[i]   <= tank_y[i*Y_W +: Y_W];
                sh_dir_q[i] <= tank_dir[i*2 +: 2];
            end
            sh_enemy_q <= tank_enemy;
            sh_alive_q <= tank_alive;
        end
    end

    // Stage A: box test and priority select
    logic [NUM_TANKS-1:0] in_box;
    logic                 win_hit;
    logic [IdxW-1:0]      win_idx;
    logic [4:0]           sel_x;
    logic [4:0]           sel_y;
    logic [1:0]           sel_dir;
    logic                 sel_enemy;
    logic [X_W:0]         px_e;
    logic [Y_W:0]         py_e;
    logic [X_W:0]         bx_lo;
    logic [X_W:0]         bx_hi;
    logic [Y_W:0]         by_lo;
    logic [Y_W:0]         by_hi;

    always_comb begin
        in_box = '0;
        px_e   = {1'b0, pix.draw_x};
        py_e   = {1'b0, pix.draw_y};
        bx_lo  = '0;
        bx_hi  = '0;
        by_lo  = '0;
        by_hi  = '0;
        // Extra MSB keeps the upper bound from wrapping near the screen edge.
        for (int unsigned i = 0; i < NUM_TANKS; i++) begin
            bx_lo     = {1'b0, sh_x_q[i]};
            bx_hi     = bx_lo + (X_W+1)'(32);
            by_lo     = {1'b0, sh_y_q[i]};
            by_hi     = by_lo + (Y_W+1)'(32);
            in_box[i] = sh_alive_q[i] & pix.pix_valid
                      & (px_e >= bx_lo) & (px_e < bx_hi)
                      & (py_e >= by_lo) & (py_e < by_hi);
        end
    end

    always_comb begin
        win_hit   = 1'b0;
        win_idx   = '0;
        sel_x     = '0;
        sel_y     = '0;
        sel_dir   = '0;
        sel_enemy = 1'b0;
        // Walk downwards so the lowest-index hit is the last one written.
        for (int i = int'(NUM_TANKS) - 1; i >= 0; i--) begin
            if (in_box[i]) begin
                win_hit   = 1'b1;
                win_idx   = IdxW'(i);
                sel_x     = sh_x_q[i][4:0];
                sel_y     = sh_y_q[i][4:0];
                sel_dir   = sh_dir_q[i];
                sel_enemy = sh_enemy_q[i];
            end
        end
    end

    // Only the low 5 bits of the offset matter, so subtract on 5 bits.
    logic [4:0] off_x;
    logic [4:0] off_y;
    logic [9:0] rom_addr_d;
    logic [9:0] rom_addr_q;

    always_comb begin
        off_x      = pix.draw_x[4:0] - sel_x;
        off_y      = pix.draw_y[4:0] - sel_y;
        rom_addr_d = win_hit ? {off_y, off_x} : 10'd0;
    end

    // Stage B address register; holds through blanking.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rom_addr_q <= '0;
        end else if (pix.pix_valid) begin
            rom_addr_q <= rom_addr_d;
        end
    end

    // Sideband delay line: entry 0 is stage B, last entry lines up with ROM data.
    logic [Depth-1:0] vld_q;
    logic [Depth-1:0] hit_q;
    logic [Depth-1:0] enemy_q;
    logic [1:0]       dir_q [Depth];
    logic [IdxW-1:0]  idx_q [Depth];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_q   <= '0;
            hit_q   <= '0;
            enemy_q <= '0;
            for (int unsigned k = 0; k < Depth; k++) begin
                dir_q[k] <= '0;
                idx_q[k] <= '0;
            end
        end else begin
            vld_q[0]   <= pix.pix_valid;
            hit_q[0]   <= win_hit;
            enemy_q[0] <= sel_enemy;
            dir_q[0]   <= sel_dir;
            idx_q[0]   <= win_idx;
            for (int unsigned k = 1; k < Depth; k++) begin
                vld_q[k]   <= vld_q[k-1];
                hit_q[k]   <= hit_q[k-1];
                enemy_q[k] <= enemy_q[k-1];
                dir_q[k]   <= dir_q[k-1];
                idx_q[k]   <= idx_q[k-1];
            end
        end
    end

    assign pix.rom_address = rom_addr_q;
    assign pix.out_valid   = vld_q[Depth-1];
    assign pix.hit         = hit_q[Depth-1];
    assign pix.enemy       = enemy_q[Depth-1];
    assign pix.dir_sel     = dir_q[Depth-1];
    assign pix.hit_index   = idx_q[Depth-1];

`ifdef SPRITE_OVERLAP_DETECT_EN
    // x & (x-1) is non-zero exactly when two or more bits are set.
    logic multi_hit;
    logic sticky_q;
    logic overlap_q;

    assign multi_hit = |(in_box & (in_box - NUM_TANKS'(1)));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sticky_q  <= 1'b0;
            overlap_q <= 1'b0;
        end else if (frame_start) begin
            overlap_q <= sticky_q | multi_hit;
            sticky_q  <= 1'b0;
        end else if (multi_hit) begin
            sticky_q  <= 1'b1;
        end
    end

    assign overlap_frame = overlap_q;
`else
    assign overlap_frame = 1'b0;
`endif

endmodule
